// File: rtl/maple_pkg.sv
// Shared state encoding, pattern lengths and line helpers for the Maple transmitter.
// MAPLE_TX_CRC_EN adds the trailing XOR byte state.
package maple_pkg;

    localparam int START_TICKS = 9;
    localparam int END_TICKS   = 6;
    localparam int BYTE_BITS   = 8;
    localparam int SLOT_W      = 4;
    localparam int DATA_SLOTS  = 2 * BYTE_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef MAPLE_TX_CRC_EN
        ST_CRC,
`endif
        ST_END
    } state_t;

    typedef struct packed {
        logic p1;
        logic p5;
    } lines_t;

    // Even bits lead on SDCKA with data on SDCKB; odd bits swap roles.
    function automatic lines_t bit_open(input logic odd, input logic d);
        lines_t l;
        if (odd) begin
            l.p1 = d;
            l.p5 = 1'b1;
        end else begin
            l.p1 = 1'b1;
            l.p5 = d;
        end
        return l;
    endfunction

endpackage

// File: rtl/maple_tick_gen.sv
// Bus tick strobe: one pulse every CLK_DIV clocks, realigned by restart.
module maple_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/maple_frame_tx.sv
// Maple bus frame transmitter: start pattern, two-phase data bits, end pattern.
// Define MAPLE_TX_CRC_EN to append the XOR of all frame bytes.
module maple_frame_tx
    import maple_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [PORT_W-1:0] port_sel_in,
    output logic [PORT_W-1:0] port_select,
    output logic              out_p1,
    output logic              out_p5,
    output logic              oe,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam logic [SLOT_W-1:0] START_LAST = SLOT_W'(START_TICKS - 1);
    localparam logic [SLOT_W-1:0] DATA_LAST  = SLOT_W'(DATA_SLOTS - 1);
    localparam logic [SLOT_W-1:0] END_LAST   = SLOT_W'(END_TICKS - 1);
    localparam logic [SLOT_W-1:0] END_P5     = SLOT_W'(END_TICKS - 2);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [7:0]        shifter;
    logic              last_q;
    logic              idle_rdy;
    logic              tick;
    logic              accept;
    logic              byte_end;
    logic              st_idle;
    logic              st_start;
    logic              st_bits;
    logic              st_end;
    logic [2:0]        bit_idx;
    logic [2:0]        nxt_bit;
    lines_t            nxt_open;
    lines_t            load_open;
`ifdef MAPLE_TX_CRC_EN
    logic [7:0]        crc;
`endif

    maple_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(accept),
        .tick   (tick)
    );

    assign st_idle  = (state == ST_IDLE);
    assign st_start = (state == ST_START);
    assign st_end   = (state == ST_END);
`ifdef MAPLE_TX_CRC_EN
    assign st_bits  = (state == ST_DATA) || (state == ST_CRC);
`else
    assign st_bits  = (state == ST_DATA);
`endif

    // Slot within a byte is {bit index, phase}; phase 1 is tick B.
    assign bit_idx   = slot[3:1];
    assign nxt_bit   = bit_idx + 3'd1;
    assign nxt_open  = bit_open(nxt_bit[0], shifter[3'd7 - nxt_bit]);
    assign load_open = bit_open(1'b0, in_data[7]);

    assign accept   = st_idle && idle_rdy && in_valid;
    assign byte_end = (state == ST_DATA) && (slot == DATA_LAST) && tick;
    assign in_ready = idle_rdy || (byte_end && !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            slot        <= '0;
            shifter     <= '0;
            last_q      <= 1'b0;
            idle_rdy    <= 1'b0;
            port_select <= '0;
            out_p1      <= 1'b1;
            out_p5      <= 1'b1;
            oe          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
            crc         <= '0;
`endif
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            unique case (1'b1)
                st_idle: begin
                    idle_rdy <= 1'b1;
                    if (accept) begin
                        state       <= ST_START;
                        slot        <= '0;
                        shifter     <= in_data;
                        last_q      <= in_last;
                        port_select <= port_sel_in;
                        idle_rdy    <= 1'b0;
                        oe          <= 1'b1;
                        busy        <= 1'b1;
                        out_p1      <= 1'b0;
                        out_p5      <= 1'b1;
`ifdef MAPLE_TX_CRC_EN
                        crc         <= in_data;
`endif
                    end
                end
                st_start: begin
                    if (tick) begin
                        if (slot == START_LAST) begin
                            state <= ST_DATA;
                            slot  <= '0;
                            {out_p1, out_p5} <= bit_open(1'b0, shifter[7]);
                        end else begin
                            slot   <= slot + SLOT_W'(1);
                            out_p5 <= slot[0];
                        end
                    end
                end
                st_bits: begin
                    if (tick) begin
                        if (!slot[0]) begin
                            slot <= slot + SLOT_W'(1);
                            if (bit_idx[0]) begin
                                out_p5 <= 1'b0;
                            end else begin
                                out_p1 <= 1'b0;
                            end
                        end else if (slot != DATA_LAST) begin
                            slot <= slot + SLOT_W'(1);
                            {out_p1, out_p5} <= nxt_open;
                        end else if (state == ST_DATA && !last_q) begin
                            slot <= '0;
                            if (in_valid) begin
                                shifter <= in_data;
                                last_q  <= in_last;
                                {out_p1, out_p5} <= load_open;
`ifdef MAPLE_TX_CRC_EN
                                crc     <= crc ^ in_data;
`endif
                            end else begin
                                // Caller stalled: close the frame early.
                                underrun <= 1'b1;
                                state    <= ST_END;
                                out_p1   <= 1'b1;
                                out_p5   <= 1'b0;
                            end
`ifdef MAPLE_TX_CRC_EN
                        end else if (state == ST_DATA) begin
                            state   <= ST_CRC;
                            slot    <= '0;
                            shifter <= crc;
                            {out_p1, out_p5} <= bit_open(1'b0, crc[7]);
`endif
                        end else begin
                            state  <= ST_END;
                            slot   <= '0;
                            out_p1 <= 1'b1;
                            out_p5 <= 1'b0;
                        end
                    end
                end
                st_end: begin
                    if (tick) begin
                        slot <= slot + SLOT_W'(1);
                        if (slot == END_LAST) begin
                            state    <= ST_IDLE;
                            slot     <= '0;
                            oe       <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            idle_rdy <= 1'b1;
                            out_p1   <= 1'b1;
                            out_p5   <= 1'b1;
                        end else if (slot == END_P5) begin
                            out_p5 <= 1'b1;
                        end else begin
                            out_p1 <= slot[0];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maple_frame_tx.sv
// Bench for maple_frame_tx: directed and random frames against a per-tick line
// table and a clock-fall byte decoder derived from the Maple bus rules.
module tb_maple_frame_tx;

    localparam int DIV     = 4;
    localparam int NP      = 4;
    localparam int PW      = 2;
    localparam int START_T = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [PW-1:0] port_sel_in = '0;
    logic [PW-1:0] port_select;
    logic          out_p1;
    logic          out_p5;
    logic          oe;
    logic          busy;
    logic          done;
    logic          underrun;

    maple_frame_tx #(
        .CLK_DIV  (DIV),
        .NUM_PORTS(NP),
        .PORT_W   (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .port_sel_in(port_sel_in),
        .port_select(port_select),
        .out_p1     (out_p1),
        .out_p5     (out_p5),
        .oe         (oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          oe;
        logic          p1;
        logic          p5;
        logic          rdy;
        logic          dn;
        logic          und;
        logic          bsy;
        logic [PW-1:0] ps;
    } samp_t;

    int         checks = 0;
    int         failures = 0;
    samp_t      rec[$];
    logic [7:0] tx_q[$];
    logic [7:0] bus_q[$];
    logic [1:0] ref_t[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {p1,p5} for every bus tick of the frame carrying bus_q.
    function automatic void build_ref();
        ref_t.delete();
        for (int i = 0; i < START_T; i++) begin
            if (i == 0) ref_t.push_back(2'b01);
            else ref_t.push_back({1'b0, (i % 2 == 0)});
        end
        foreach (bus_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                logic d;
                d = bus_q[k][7 - b];
                if (b % 2 == 0) begin
                    ref_t.push_back({1'b1, d});
                    ref_t.push_back({1'b0, d});
                end else begin
                    ref_t.push_back({d, 1'b1});
                    ref_t.push_back({d, 1'b0});
                end
            end
        end
        ref_t.push_back(2'b10);
        ref_t.push_back(2'b00);
        ref_t.push_back(2'b10);
        ref_t.push_back(2'b00);
        ref_t.push_back(2'b10);
        ref_t.push_back(2'b11);
    endfunction

    task automatic check_frame(input string nm, input int n_acc, input bit drop,
                               input logic [PW-1:0] port);
        int first = -1;
        int last = -1;
        int oe_n = 0;
        int rdy_n = 0;
        int done_n = 0;
        int done_at = -1;
        int und_n = 0;
        int und_at = -1;
        int ps_bad = 0;
        int busy_bad = 0;
        int line_bad = 0;
        int nb = 0;
        bit want_p1 = 1'b1;
        logic [7:0] acc = '0;
        logic [7:0] got_q[$];
        logic [7:0] g;
        int tt;
        foreach (rec[i]) begin
            if (rec[i].oe) begin
                if (first < 0) first = i;
                last = i;
                oe_n++;
                if (rec[i].rdy) rdy_n++;
                if (rec[i].ps !== port) ps_bad++;
            end
            if (rec[i].bsy !== rec[i].oe) busy_bad++;
            if (rec[i].dn) begin done_n++; done_at = i; end
            if (rec[i].und) begin und_n++; und_at = i; end
        end
        if (first < 0) first = 0;
        tt = ref_t.size();
        chk({nm, ":oe_cycles"}, oe_n, tt * DIV);
        chk({nm, ":oe_span"}, last - first + 1, tt * DIV);
        for (int t = 0; t < tt; t++) begin
            int ix;
            ix = first + t * DIV + DIV / 2;
            if (ix >= rec.size()) line_bad++;
            else if ({rec[ix].p1, rec[ix].p5} !== ref_t[t]) line_bad++;
        end
        chk({nm, ":line_ticks_bad"}, line_bad, 0);
        for (int i = first + START_T * DIV; i < rec.size() && i <= last; i++) begin
            if (i == 0) continue;
            if (want_p1 && rec[i-1].p1 && !rec[i].p1) begin
                acc = {acc[6:0], rec[i].p5};
                nb++;
                want_p1 = 1'b0;
            end else if (!want_p1 && rec[i-1].p5 && !rec[i].p5) begin
                acc = {acc[6:0], rec[i].p1};
                nb++;
                want_p1 = 1'b1;
            end
            if (nb == 8) begin
                got_q.push_back(acc);
                nb = 0;
            end
            if (got_q.size() == bus_q.size()) break;
        end
        chk({nm, ":nbytes"}, got_q.size(), bus_q.size());
        foreach (bus_q[k]) begin
            g = (k < got_q.size()) ? got_q[k] : 8'hxx;
            chk($sformatf("%s:byte%0d", nm, k), g, bus_q[k]);
        end
        chk({nm, ":rdy_pulses"}, rdy_n, drop ? n_acc : n_acc - 1);
        chk({nm, ":done_n"}, done_n, 1);
        chk({nm, ":done_at"}, done_at, last + 1);
        chk({nm, ":underrun_n"}, und_n, drop ? 1 : 0);
        if (drop) chk({nm, ":underrun_at"}, und_at, first + (START_T + 16 * n_acc) * DIV);
        chk({nm, ":port_bad"}, ps_bad, 0);
        chk({nm, ":busy_bad"}, busy_bad, 0);
    endtask

    task automatic run_frame(input string nm, input logic [PW-1:0] port,
                             input bit drop, input bit noisy);
        int idx = 0;
        int cyc = 0;
        int after = 0;
        bit fin = 1'b0;
        logic [7:0] x = '0;
        bus_q = tx_q;
`ifdef MAPLE_TX_CRC_EN
        if (!drop) begin
            foreach (tx_q[k]) x ^= tx_q[k];
            bus_q.push_back(x);
        end
`endif
        build_ref();
        rec.delete();
        port_sel_in = port;
        while (after < 4 && cyc < 3000) begin
            @(negedge clk);
            rec.push_back({oe, out_p1, out_p5, in_ready, done, underrun, busy,
                           port_select});
            if (done) fin = 1'b1;
            if (fin) after++;
            if (idx < tx_q.size() && (in_ready || !noisy)) begin
                in_valid = 1'b1;
                in_data  = tx_q[idx];
                in_last  = !drop && (idx == tx_q.size() - 1);
            end else begin
                in_valid = noisy && idx < tx_q.size() ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            if (in_ready && in_valid) idx++;
            if (!in_ready && idx > 0) port_sel_in = PW'($urandom);
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, ":finished"}, fin, 1'b1);
        check_frame(nm, tx_q.size(), drop, port);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lines", {oe, out_p1, out_p5, in_ready, busy, done, underrun},
            7'b0110000);
        chk("rst_port", port_select, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rdy_after_rst", in_ready, 1'b1);

        tx_q = '{8'hA5};
        run_frame("a5", 2'd2, 1'b0, 1'b1);

        tx_q = '{8'h01, 8'h80, 8'hFF};
        run_frame("burst3", 2'd1, 1'b0, 1'b0);

        tx_q = '{8'h3C};
        run_frame("underrun", 2'd3, 1'b1, 1'b1);

        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'hC3;
        in_last = 1'b1;
        port_sel_in = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_frame_oe", oe, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {oe, out_p1, out_p5, busy, in_ready, port_select},
               {5'b01100, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_q = '{8'h96, 8'h0F};
        run_frame("after_rst", 2'd0, 1'b0, 1'b1);

        tx_q = '{8'h12, 8'h34};
        run_frame("xor2", 2'd1, 1'b0, 1'b1);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 4);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", f), PW'($urandom),
                      ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
